// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the parametrised SPI master:
//   state_t        - transfer sequencer states (IDLE, LEAD, XFER, TRAIL)
//   SPI_MODE0..3   - SPI mode encodings as {CPOL, CPHA}
//   sel_width()    - width of a chip-select index for a given line count
// No ports; imported by spi_clk_gen and spi_master_gen.
// -----------------------------------------------------------------------------
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEAD  = 2'd1,
        XFER  = 2'd2,
        TRAIL = 2'd3
    } state_t;

    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    // A single chip select still needs a one-bit index port.
    function automatic int sel_width(input int num_cs);
        return (num_cs > 1) ? $clog2(num_cs) : 1;
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// -----------------------------------------------------------------------------
// spi_clk_gen
// Half-period tick generator. While enabled, o_tick is high for one cycle
// out of every CLK_DIV cycles, the first one CLK_DIV cycles after enable
// rises. Disabling the block clears the count so every enable starts a
// fresh, aligned half-period.
// Ports:
//   i_clock   system clock
//   i_reset   synchronous active-high reset
//   i_enable  run the counter; low holds it at zero
//   o_tick    one-cycle pulse at the end of each half-period
// -----------------------------------------------------------------------------
module spi_clk_gen
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 1
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_enable,
    output logic o_tick
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_wrap;

    assign w_wrap = (r_cnt == CNT_LAST);
    // The tick is decoded from the count so the sequencer acts on the very
    // edge that ends the half-period; the sequencer registers everything
    // it drives off-chip.
    assign o_tick = i_enable && w_wrap;

    // NOTE: sequential state is always assigned with <= so every flop
    // samples the pre-edge value of its neighbours, independent of
    // statement order.
    always_ff @(posedge i_clock) begin
        if (i_reset || !i_enable) begin
            r_cnt <= '0;
        end else if (w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_master_gen.sv
// -----------------------------------------------------------------------------
// spi_master_gen
// Parametrised SPI master. Accepts a DATA_W-bit word on a valid/ready
// handshake, shifts it out on o_mosi while capturing i_miso, and returns
// the received word with a one-cycle o_done pulse. Supports all four
// CPOL/CPHA modes, LSB- or MSB-first order, NUM_CS chip selects and
// CLK_DIV-cycle CS lead/trail time. All outputs are registered.
// Ports:
//   i_clock       system clock
//   i_reset       synchronous active-high reset, aborts any transfer
//   i_data_in     word to transmit, sampled at accept
//   i_cs_sel      target slave index, sampled at accept
//   i_data_valid  request; accepted when i_data_valid && o_ready
//   o_ready       idle and able to accept
//   o_data_out    last received word, held until the next o_done
//   o_done        one-cycle pulse at the end of a transfer
//   o_sclk        SPI clock
//   o_mosi        serial data out
//   i_miso        serial data in
//   o_cs_n        active-low chip selects
// -----------------------------------------------------------------------------
module spi_master_gen
    import spi_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int CLK_DIV   = 1,
    parameter int CPOL      = 0,
    parameter int CPHA      = 0,
    parameter int LSB_FIRST = 1,
    parameter int NUM_CS    = 1,
    localparam int SEL_W    = sel_width(NUM_CS)
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic [DATA_W-1:0] i_data_in,
    input  logic [SEL_W-1:0]  i_cs_sel,
    input  logic              i_data_valid,
    output logic              o_ready,
    output logic [DATA_W-1:0] o_data_out,
    output logic              o_done,
    output logic              o_sclk,
    output logic              o_mosi,
    input  logic              i_miso,
    output logic [NUM_CS-1:0] o_cs_n
);

    // Counts sclk toggles within a transfer: 0 .. 2*DATA_W.
    localparam int EDGE_W = $clog2(2 * DATA_W + 1);
    localparam logic [EDGE_W-1:0] LAST_CNT = EDGE_W'(2 * DATA_W);
    localparam logic [1:0] MODE           = {1'(CPOL), 1'(CPHA)};
    localparam logic       IDLE_SCLK      = 1'(CPOL);
    localparam logic       SAMPLE_ON_LEAD = (MODE == SPI_MODE0) || (MODE == SPI_MODE2);

    state_t              r_state;
    logic [DATA_W-1:0]   r_tx;
    logic [DATA_W-1:0]   r_rx;
    logic [SEL_W-1:0]    r_sel;
    logic [EDGE_W-1:0]   r_edge_cnt;
    logic                r_tick_en;
    logic                r_setup;
    logic                r_ready;
    logic [DATA_W-1:0]   r_data_out;
    logic                r_done;
    logic                r_sclk;
    logic                r_mosi;
    logic [NUM_CS-1:0]   r_cs_n;

    logic                w_tick;
    logic                w_toggle;
    logic                w_lead_edge;
    logic                w_last_edge;
    logic                w_tx_bit;
    logic [DATA_W-1:0]   w_tx_next;
    logic [DATA_W-1:0]   w_rx_next;
    logic [NUM_CS-1:0]   w_cs_sel_n;

    spi_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .i_clock  (i_clock),
        .i_reset  (i_reset),
        .i_enable (r_tick_en),
        .o_tick   (w_tick)
    );

    // NOTE: every signal written in this block gets a value before any
    // conditional logic, so no path leaves it unassigned and no latch is
    // inferred.
    always_comb begin
        w_tx_bit   = r_tx[DATA_W-1];
        w_tx_next  = {r_tx[DATA_W-2:0], 1'b0};
        w_rx_next  = {r_rx[DATA_W-2:0], i_miso};
        w_cs_sel_n = '1;
        if (LSB_FIRST != 0) begin
            w_tx_bit  = r_tx[0];
            w_tx_next = {1'b0, r_tx[DATA_W-1:1]};
            // First received bit ends up in bit 0 after DATA_W samples.
            w_rx_next = {i_miso, r_rx[DATA_W-1:1]};
        end
        // Out-of-range selects match no line, so all stay deasserted.
        for (int i = 0; i < NUM_CS; i++) begin
            w_cs_sel_n[i] = (int'(r_sel) != i);
        end
    end

    // The tick that ends LEAD is the first (leading) toggle; the tick after
    // toggle 2*DATA_W only closes the final half-period.
    assign w_toggle    = w_tick && ((r_state == LEAD) ||
                                    (r_state == XFER && r_edge_cnt != LAST_CNT));
    assign w_lead_edge = ~r_edge_cnt[0];
    assign w_last_edge = (r_edge_cnt == LAST_CNT - EDGE_W'(1));

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state    <= IDLE;
            r_tx       <= '0;
            r_rx       <= '0;
            r_sel      <= '0;
            r_edge_cnt <= '0;
            r_tick_en  <= 1'b0;
            r_setup    <= 1'b0;
            r_ready    <= 1'b1;
            r_data_out <= '0;
            r_done     <= 1'b0;
            r_sclk     <= IDLE_SCLK;
            r_mosi     <= 1'b0;
            r_cs_n     <= '1;
        end else begin
            r_done <= 1'b0;

            if (w_toggle) begin
                r_sclk     <= ~r_sclk;
                r_edge_cnt <= r_edge_cnt + 1'b1;
                if (w_lead_edge == SAMPLE_ON_LEAD) begin
                    r_rx <= w_rx_next;
                end else if (!w_last_edge) begin
                    // Present the head bit and advance; with CPHA=0 the
                    // final trailing edge has nothing left to shift.
                    r_mosi <= w_tx_bit;
                    r_tx   <= w_tx_next;
                end
            end

            case (r_state)
                IDLE: begin
                    if (i_data_valid && r_ready) begin
                        r_tx    <= i_data_in;
                        r_sel   <= i_cs_sel;
                        // Drop ready on the accept edge so a held valid
                        // cannot be taken twice.
                        r_ready <= 1'b0;
                        r_setup <= 1'b1;
                        r_state <= LEAD;
                    end
                end
                LEAD: begin
                    if (r_setup) begin
                        // First LEAD cycle: assert CS, start the half-period
                        // timer and, for CPHA=0, put bit 0 on the wire.
                        r_setup   <= 1'b0;
                        r_cs_n    <= w_cs_sel_n;
                        r_tick_en <= 1'b1;
                        if (CPHA == 0) begin
                            r_mosi <= w_tx_bit;
                            r_tx   <= w_tx_next;
                        end
                    end else if (w_tick) begin
                        r_state <= XFER;
                    end
                end
                XFER: begin
                    if (w_tick && r_edge_cnt == LAST_CNT) begin
                        r_state <= TRAIL;
                    end
                end
                TRAIL: begin
                    if (w_tick) begin
                        r_state    <= IDLE;
                        r_cs_n     <= '1;
                        r_done     <= 1'b1;
                        r_ready    <= 1'b1;
                        r_data_out <= r_rx;
                        r_tick_en  <= 1'b0;
                        r_edge_cnt <= '0;
                        r_mosi     <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_ready    = r_ready;
    assign o_data_out = r_data_out;
    assign o_done     = r_done;
    assign o_sclk     = r_sclk;
    assign o_mosi     = r_mosi;
    assign o_cs_n     = r_cs_n;

endmodule
